// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped saturating-counter direction predictor with lookup/mispredict statistics.
// Define BRANCH_PREDICTOR_BTB_EN to compile in a tagged branch target buffer alongside the counters.
module branch_predictor #(
  parameter int PC_W     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 2,
  parameter int TAG_W    = 8,
  parameter int STAT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pred_valid_i,
  input  logic [PC_W-1:0]   pred_pc_i,
  output logic              pred_taken_o,
  output logic              pred_hit_o,
  output logic [PC_W-1:0]   pred_target_o,
  input  logic              upd_valid_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic              upd_pred_taken_i,
  input  logic [PC_W-1:0]   upd_target_i,
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_lookups_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CTR_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]    r_ctr [ENTRIES];
  logic [STAT_W-1:0]   r_lookups;
  logic [STAT_W-1:0]   r_mispred;
  logic [IDX_BITS-1:0] w_pred_idx;
  logic [IDX_BITS-1:0] w_upd_idx;
  logic [TAG_W-1:0]    w_pred_tag;
  logic [TAG_W-1:0]    w_upd_tag;
  logic                w_ctr_msb;
  logic                w_unused;

  assign w_pred_idx = pred_pc_i[IDX_BITS+1:2];
  assign w_upd_idx  = upd_pc_i[IDX_BITS+1:2];
  assign w_pred_tag = pred_pc_i[IDX_BITS+1+TAG_W:IDX_BITS+2];
  assign w_upd_tag  = upd_pc_i[IDX_BITS+1+TAG_W:IDX_BITS+2];
  assign w_ctr_msb  = r_ctr[w_pred_idx][CNT_W-1];

  // Lookups read the registered table, so a same-cycle update is seen only next cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
    end else if (upd_valid_i) begin
      if (upd_taken_i && (r_ctr[w_upd_idx] != '1))
        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 1'b1;
      else if (!upd_taken_i && (r_ctr[w_upd_idx] != '0))
        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 1'b1;
    end
  end

  // Clear beats increment; both counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lookups <= '0;
      r_mispred <= '0;
    end else if (stat_clr_i) begin
      r_lookups <= '0;
      r_mispred <= '0;
    end else begin
      if (pred_valid_i && (r_lookups != '1))
        r_lookups <= r_lookups + 1'b1;
      if (upd_valid_i && (upd_taken_i != upd_pred_taken_i) && (r_mispred != '1))
        r_mispred <= r_mispred + 1'b1;
    end
  end

  assign stat_lookups_o = r_lookups;
  assign stat_mispred_o = r_mispred;

`ifdef BRANCH_PREDICTOR_BTB_EN
  logic [ENTRIES-1:0] r_btb_valid;
  logic [TAG_W-1:0]   r_btb_tag    [ENTRIES];
  logic [PC_W-1:0]    r_btb_target [ENTRIES];
  logic               w_hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_btb_valid <= '0;
    else if (upd_valid_i && upd_taken_i)
      r_btb_valid[w_upd_idx] <= 1'b1;
  end

  // Tag and target are meaningless while valid is clear, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i && upd_taken_i) begin
      r_btb_tag[w_upd_idx]    <= w_upd_tag;
      r_btb_target[w_upd_idx] <= upd_target_i;
    end
  end

  assign w_hit         = r_btb_valid[w_pred_idx] && (r_btb_tag[w_pred_idx] == w_pred_tag);
  assign pred_hit_o    = w_hit;
  assign pred_taken_o  = w_hit && w_ctr_msb;
  assign pred_target_o = w_hit ? r_btb_target[w_pred_idx] : '0;
  assign w_unused      = ^{pred_pc_i, upd_pc_i};
`else
  assign pred_hit_o    = 1'b0;
  assign pred_taken_o  = w_ctr_msb;
  assign pred_target_o = '0;
  assign w_unused      = ^{pred_pc_i, upd_pc_i, upd_target_i, w_pred_tag, w_upd_tag};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against an arithmetic reference model.
`timescale 1ns/1ps
module tb_branch_predictor;

   localparam int PC_W         = 32;
   localparam int IDX_BITS     = 6;
   localparam int CNT_W        = 2;
   localparam int TAG_W        = 8;
   localparam int STAT_W       = 16;
   localparam int SMALL_STAT_W = 4;
   localparam int ENTRIES      = 1 << IDX_BITS;
   localparam int CTR_MAX      = (1 << CNT_W) - 1;
   localparam int TAKEN_THRESH = 1 << (CNT_W - 1);
   localparam int STAT_MAX     = (1 << STAT_W) - 1;
   localparam int SMALL_MAX    = (1 << SMALL_STAT_W) - 1;

   logic clk;
   logic rstN;
   logic predValid;
   logic [PC_W-1:0] predPc;
   logic predTaken;
   logic predHit;
   logic [PC_W-1:0] predTarget;
   logic updValid;
   logic [PC_W-1:0] updPc;
   logic updTaken;
   logic updPredTaken;
   logic [PC_W-1:0] updTarget;
   logic statClr;
   logic [STAT_W-1:0] statLookups;
   logic [STAT_W-1:0] statMispred;
   logic smallTaken;
   logic smallHit;
   logic [PC_W-1:0] smallTarget;
   logic [SMALL_STAT_W-1:0] smallLookups;
   logic [SMALL_STAT_W-1:0] smallMispred;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference state: plain integers for counters and unbounded event counts.
   int modelCtr [ENTRIES];
   bit modelValid [ENTRIES];
   int modelTag [ENTRIES];
   logic [PC_W-1:0] modelTarget [ENTRIES];
   int modelLookups;
   int modelMispred;

   branch_predictor #(.PC_W(PC_W), .IDX_BITS(IDX_BITS), .CNT_W(CNT_W), .TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
      .clk_i(clk), .rst_i(rstN),
      .pred_valid_i(predValid), .pred_pc_i(predPc),
      .pred_taken_o(predTaken), .pred_hit_o(predHit), .pred_target_o(predTarget),
      .upd_valid_i(updValid), .upd_pc_i(updPc), .upd_taken_i(updTaken),
      .upd_pred_taken_i(updPredTaken), .upd_target_i(updTarget),
      .stat_clr_i(statClr), .stat_lookups_o(statLookups), .stat_mispred_o(statMispred)
   );

   // Narrow-statistics copy sharing the same stimulus, used to reach saturation quickly.
   branch_predictor #(.PC_W(PC_W), .IDX_BITS(IDX_BITS), .CNT_W(CNT_W), .TAG_W(TAG_W), .STAT_W(SMALL_STAT_W)) dutSmall (
      .clk_i(clk), .rst_i(rstN),
      .pred_valid_i(predValid), .pred_pc_i(predPc),
      .pred_taken_o(smallTaken), .pred_hit_o(smallHit), .pred_target_o(smallTarget),
      .upd_valid_i(updValid), .upd_pc_i(updPc), .upd_taken_i(updTaken),
      .upd_pred_taken_i(updPredTaken), .upd_target_i(updTarget),
      .stat_clr_i(statClr), .stat_lookups_o(smallLookups), .stat_mispred_o(smallMispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int idxOf(input logic [PC_W-1:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int tagOf(input logic [PC_W-1:0] pc);
      return int'((pc >> (IDX_BITS + 2)) % (1 << TAG_W));
   endfunction

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         modelCtr[i] = TAKEN_THRESH - 1;
         modelValid[i] = 1'b0;
         modelTag[i] = 0;
         modelTarget[i] = '0;
      end
      modelLookups = 0;
      modelMispred = 0;
   endtask

   // Compare the combinational lookup outputs with the model's view of predPc.
   task automatic checkLookup(input string tag);
      int idx;
      bit dirTaken;
      bit expHit;
      bit expTaken;
      logic [PC_W-1:0] expTarget;
      idx = idxOf(predPc);
      dirTaken = (modelCtr[idx] >= TAKEN_THRESH);
`ifdef BRANCH_PREDICTOR_BTB_EN
      expHit = modelValid[idx] && (modelTag[idx] == tagOf(predPc));
      expTaken = expHit && dirTaken;
      expTarget = expHit ? modelTarget[idx] : '0;
`else
      expHit = 1'b0;
      expTaken = dirTaken;
      expTarget = '0;
`endif
      checkOutput({tag, "_taken"}, 32'(predTaken), 32'(expTaken));
      checkOutput({tag, "_hit"}, 32'(predHit), 32'(expHit));
      checkOutput({tag, "_target"}, predTarget, expTarget);
   endtask

   task automatic checkStats(input string tag);
      checkOutput({tag, "_lookups"}, 32'(statLookups), (modelLookups > STAT_MAX) ? STAT_MAX : modelLookups);
      checkOutput({tag, "_mispred"}, 32'(statMispred), (modelMispred > STAT_MAX) ? STAT_MAX : modelMispred);
      checkOutput({tag, "_small_lookups"}, 32'(smallLookups), (modelLookups > SMALL_MAX) ? SMALL_MAX : modelLookups);
      checkOutput({tag, "_small_mispred"}, 32'(smallMispred), (modelMispred > SMALL_MAX) ? SMALL_MAX : modelMispred);
   endtask

   task automatic idleInputs();
      predValid = 1'b0;
      predPc = '0;
      updValid = 1'b0;
      updPc = '0;
      updTaken = 1'b0;
      updPredTaken = 1'b0;
      updTarget = '0;
      statClr = 1'b0;
   endtask

   // One clock: drive, check lookup before the edge, advance the model, check statistics after it.
   task automatic applyStimulus(input bit pv, input logic [PC_W-1:0] ppc, input bit uv,
                                input logic [PC_W-1:0] upc, input bit ut, input bit upt,
                                input logic [PC_W-1:0] utgt, input bit clr);
      int idx;
      predValid = pv;
      predPc = ppc;
      updValid = uv;
      updPc = upc;
      updTaken = ut;
      updPredTaken = upt;
      updTarget = utgt;
      statClr = clr;
      #1;
      checkLookup("lookup");
      if (clr) begin
         modelLookups = 0;
         modelMispred = 0;
      end else begin
         if (pv) modelLookups++;
         if (uv && (ut != upt)) modelMispred++;
      end
      if (uv) begin
         idx = idxOf(upc);
         modelCtr[idx] = ut ? ((modelCtr[idx] + 1 > CTR_MAX) ? CTR_MAX : modelCtr[idx] + 1)
                            : ((modelCtr[idx] - 1 < 0) ? 0 : modelCtr[idx] - 1);
         if (ut) begin
            modelValid[idx] = 1'b1;
            modelTag[idx] = tagOf(upc);
            modelTarget[idx] = utgt;
         end
      end
      @(posedge clk);
      #1;
      checkStats("stats");
   endtask

   // Asynchronous reset landing while a taken update to 0x100 is being presented.
   task automatic doReset();
      logic [PC_W-1:0] resetPcs [3];
      resetPcs[0] = 32'h0;
      resetPcs[1] = 32'h40;
      resetPcs[2] = 32'hFFC;
      idleInputs();
      updValid = 1'b1;
      updPc = 32'h100;
      updTaken = 1'b1;
      updTarget = 32'h900;
      predValid = 1'b1;
      rstN = 1'b0;
      #1;
      modelReset();
      checkStats("reset");
      for (int i = 0; i < 3; i++) begin
         predPc = resetPcs[i];
         #1;
         checkOutput("reset_taken", 32'(predTaken), 32'h0);
         checkOutput("reset_hit", 32'(predHit), 32'h0);
         checkOutput("reset_target", predTarget, 32'h0);
      end
      @(posedge clk);
      #1;
      rstN = 1'b1;
      idleInputs();
      predPc = 32'h100;
      #1;
      checkLookup("reset_lost_update");
   endtask

   initial begin
      idleInputs();
      rstN = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;

      $display("[TB] same-cycle lookup/update conflict");
      doReset();
      applyStimulus(1, 32'h200, 1, 32'h200, 1, 0, 32'h300, 0);
      predPc = 32'h200;
      #1;
      checkOutput("conflict_after", 32'(predTaken), 32'h1);

      $display("[TB] counter saturation");
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1, 32'h100, 1, 32'h100, 1, 1'($urandom), 32'h500, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 32'h100, 1, 32'h100, 0, 1'($urandom), 32'h0, 0);
      applyStimulus(1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0);
      checkOutput("sat_low_taken", 32'(predTaken), 32'h0);

      $display("[TB] aliasing and tags");
      doReset();
      applyStimulus(1, 32'h104, 1, 32'h104, 1, 0, 32'h80, 0);
      applyStimulus(1, 32'h104, 0, 32'h0, 0, 0, 32'h0, 0);
      applyStimulus(1, 32'h204, 0, 32'h0, 0, 0, 32'h0, 0);

      $display("[TB] statistics");
      doReset();
      for (int i = 0; i < 10; i++)
         applyStimulus(1, $urandom & 32'h3FFC, (i < 3), 32'h40 + 32'(i * 4), 1, 0, 32'h0, 0);
      checkOutput("stat_lookups_10", 32'(statLookups), 32'd10);
      checkOutput("stat_mispred_3", 32'(statMispred), 32'd3);
      applyStimulus(1, 32'h0, 1, 32'h0, 0, 1, 32'h0, 1);
      checkOutput("clr_priority", 32'(statLookups), 32'd0);
      for (int i = 0; i < 20; i++) applyStimulus(1, $urandom, 0, 32'h0, 0, 0, 32'h0, 0);
      checkOutput("small_saturate", 32'(smallLookups), 32'd15);

      $display("[TB] randomized traffic");
      doReset();
      for (int i = 0; i < 600; i++) begin
         if (i == 300) doReset();
         applyStimulus(1'($urandom), $urandom & 32'h3FFF, 1'($urandom), $urandom & 32'h3FFF,
                       1'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 40) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It holds a direct-mapped table of saturating direction counters, optionally paired with a tagged branch target buffer. The fetch stage looks it up with the current PC. The branch unit in ID writes the resolved outcome back. Two saturating statistics counters track lookups and direction mispredictions.

## Interface
- `PC_W`, default 32: PC / target width.
- `IDX_BITS`, default 6: table index width; ENTRIES = 2^IDX_BITS.
- `CNT_W`, default 2: direction counter width (≥1).
- `TAG_W`, default 8: BTB tag width; only used with the BTB. Constraint: IDX_BITS+2+TAG_W ≤ PC_W.
- `STAT_W`, default 16: statistics counter width.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `pred_valid_i` in 1: fetch lookup qualifier.
- `pred_pc_i` in PC_W: fetch PC.
- `pred_taken_o` out 1: predicted taken.
- `pred_hit_o` out 1: BTB hit.
- `pred_target_o` out PC_W: predicted target.
- `upd_valid_i` in 1: resolved branch update strobe.
- `upd_pc_i` in PC_W: PC of the resolved branch.
- `upd_taken_i` in 1: actual outcome.
- `upd_pred_taken_i` in 1: prediction that was made for this branch, carried down the pipe.
- `upd_target_i` in PC_W: actual target from the ID adder.
- `stat_clr_i` in 1: synchronous clear of both statistics counters.
- `stat_lookups_o` out STAT_W: lookup count.
- `stat_mispred_o` out STAT_W: misprediction count.

## Operation
**Indexing**
- idx = pc[IDX_BITS+1:2].
- tag = pc[IDX_BITS+1+TAG_W:IDX_BITS+2].
- PC bits [1:0] are ignored.

**Lookup** is combinational from `pred_pc_i` against the registered tables.
- ctr[idx] MSB = 1 means predict taken.
- Outputs do not depend on `pred_valid_i`; that signal only gates statistics.

**Update**, when `upd_valid_i` = 1 at the clock edge:
- ctr[idx] increments if `upd_taken_i` = 1, saturating at 2^CNT_W−1.
- ctr[idx] decrements if `upd_taken_i` = 0, saturating at 0.
- Other entries are unchanged.

**Aliasing:** distinct PCs with the same idx share a counter. No disambiguation is done without the BTB.

**Statistics** (both counters saturate at 2^STAT_W−1 and never wrap):
- `stat_lookups_o` +1 per cycle with `pred_valid_i` = 1.
- `stat_mispred_o` +1 per cycle with `upd_valid_i` = 1 and `upd_taken_i` ≠ `upd_pred_taken_i`.
- `stat_clr_i` has priority over the increments in the same cycle.

**Reset values:**
- Every ctr = 2^(CNT_W−1)−1, i.e. weakly not-taken (01 for CNT_W=2).
- All BTB valid bits = 0; stored tags and targets are don't-care.
- Statistics = 0.
- Consequence: `pred_taken_o` = 0, `pred_hit_o` = 0 and `pred_target_o` = 0 for every PC.

## Timing
- Lookup latency is 0 cycles; outputs are a combinational function of `pred_pc_i` and table state.
- Update latency is 1 cycle; the new state is visible to a lookup in the cycle after the `upd_valid_i` edge.
- Simultaneous lookup and update to the same idx: the lookup returns the pre-update value (no write-through bypass).
- Reset is asynchronous on assertion. It may land mid-update: the table and statistics go to reset values immediately, and an update in progress is lost.
- An update applied in the same cycle as `stat_clr_i` still updates the tables.
- Stall and flush are handled outside this block. The pipeline must not assert `upd_valid_i` for a flushed branch.

## Configuration
- With `BRANCH_PREDICTOR_BTB_EN` defined, a BTB is compiled in.
  - Per entry: valid, tag and target.
  - Each update with `upd_taken_i` = 1 writes valid=1, tag(`upd_pc_i`) and `upd_target_i`.
  - Not-taken updates leave the BTB untouched.
  - `pred_hit_o` = valid[idx] & (tag[idx] == tag(`pred_pc_i`)).
  - `pred_taken_o` = `pred_hit_o` & ctr MSB.
  - `pred_target_o` = the stored target on a hit, else 0.
- Without the macro, no BTB storage exists.
  - `pred_hit_o` = 0 and `pred_target_o` = 0.
  - `pred_taken_o` = ctr MSB; the ID stage supplies the target.

## Test plan
1. **Reset:** drive `rst_i`=0 mid-run. Lookups of pc 0x0, 0x40 and 0xFFC give taken=0, hit=0, target=0. Both statistics read 0 without waiting for a clock edge.
2. **Counter saturation** (CNT_W=2):
   - Three taken updates at pc 0x100 move ctr 01→10→11→11; `pred_taken_o`=1 from the cycle after the first update.
   - Then three not-taken updates move 11→10→01→00; `pred_taken_o`=0 from the cycle after the second.
3. **Same-cycle conflict:** lookup and taken update at pc 0x200 in the same cycle with ctr=01. Lookup gives taken=0 that cycle and taken=1 in the next.
4. **Aliasing / BTB tag:** with IDX_BITS=6, pc 0x104 and 0x204 share idx 1.
   - BTB_EN build: a taken update at 0x104 with target 0x80 gives hit=1, target=0x80 for 0x104, and hit=0, taken=0 for 0x204.
   - Non-BTB build: both PCs report the same taken value.
5. **Statistics:**
   - 10 lookups and 3 updates with `upd_taken_i` ≠ `upd_pred_taken_i` give lookups=10, mispred=3.
   - `stat_clr_i` together with `pred_valid_i` gives 0, not 1.
   - With STAT_W=4, 20 lookups saturate at 15.
